// File: rtl/cache_miss_ctrl_pkg.sv
// cache_pkg: shared constants and the controller state type for cache_miss_ctrl.
//   ADDR_W     - main-memory byte address width
//   DATA_W     - byte width of every data path
//   LINE_BEATS - bytes per cache line, one byte per memory beat
//   BEAT_W     - width of a beat index within a line
//   state_t    - IDLE / WB (write back victim) / FILL (refill line) / DONE
package cache_pkg;

   localparam int ADDR_W     = 9;
   localparam int DATA_W     = 8;
   localparam int LINE_BEATS = 4;
   localparam int BEAT_W     = $clog2(LINE_BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: bundles the CPU/cache side and the memory side of the
// miss controller.
//   master modport - the controller (drives memory requests, fill, stall, done)
//   slave modport  - the environment (cache + CPU + main memory)
// Signals: miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
// beat_idx, addr_mem, rd_mem, wr_mem, data_mem_out, data_mem_in, ready_mem,
// fill_we, fill_data, stall_cpu, miss_done.
interface cache_miss_ctrl_if;
   import cache_pkg::*;

   logic              miss_req;
   logic [ADDR_W-1:0] miss_addr;
   logic              victim_dirty;
   logic [ADDR_W-1:0] victim_addr;
   logic [DATA_W-1:0] victim_data;
   logic [BEAT_W-1:0] beat_idx;
   logic [ADDR_W-1:0] addr_mem;
   logic              rd_mem;
   logic              wr_mem;
   logic [DATA_W-1:0] data_mem_out;
   logic [DATA_W-1:0] data_mem_in;
   logic              ready_mem;
   logic              fill_we;
   logic [DATA_W-1:0] fill_data;
   logic              stall_cpu;
   logic              miss_done;

   modport master (
      input  miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
             data_mem_in, ready_mem,
      output beat_idx, addr_mem, rd_mem, wr_mem, data_mem_out,
             fill_we, fill_data, stall_cpu, miss_done
   );

   modport slave (
      output miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
             data_mem_in, ready_mem,
      input  beat_idx, addr_mem, rd_mem, wr_mem, data_mem_out,
             fill_we, fill_data, stall_cpu, miss_done
   );

endinterface

// File: rtl/mem_beat_cnt.sv
// mem_beat_cnt: beat counter for one line transfer.
//   clock, reset_n - rising-edge clock, synchronous active-low reset
//   load, load_val - start a new transfer at beat index load_val
//   inc            - a beat completed; advance modulo LINE_BEATS
//   cnt            - current beat index
//   last           - the current beat is the final one of the line
// The start index is remembered so a transfer that begins mid-line (wrapping
// order) still ends after exactly LINE_BEATS beats.
module mem_beat_cnt
   import cache_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic [BEAT_W-1:0] load_val,
   input  logic              inc,
   output logic [BEAT_W-1:0] cnt,
   output logic              last
);

   logic [BEAT_W-1:0] start_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt     <= '0;
         start_q <= '0;
      end else if (load) begin
         cnt     <= load_val;
         start_q <= load_val;
      end else if (inc) begin
         cnt <= cnt + BEAT_W'(1);
      end
   end

   // Final beat is the one just before wrapping back to the start index.
   assign last = ((cnt + BEAT_W'(1)) == start_q);

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: services a cache miss by optionally writing back a dirty
// victim line (WB) and then refilling the missing line (FILL), one byte per beat.
//   clock, reset_n - rising-edge clock, synchronous active-low reset
//   bus (master)   - CPU/cache request side and main-memory side, see
//                    cache_miss_ctrl_if
// Optional feature: define CACHE_CRITICAL_WORD_FIRST_EN to start the refill at
// the missing byte and wrap; write-back order is always 0..3.
module cache_miss_ctrl
   import cache_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   cache_miss_ctrl_if.master bus
);

   state_t                   state_q, state_d;
   logic [ADDR_W-BEAT_W-1:0] miss_base_q, victim_base_q;
   logic [BEAT_W-1:0]        cnt, cnt_load_val, fill_start_new, fill_start_held;
   logic                     last, accept, beat_done, cnt_load, wb_end;

   assign accept    = (state_q == IDLE) && bus.miss_req;
   assign beat_done = ((state_q == WB) || (state_q == FILL)) && bus.ready_mem;
   assign wb_end    = (state_q == WB) && beat_done && last;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   logic [BEAT_W-1:0] crit_q;

   always_ff @(posedge clock) begin
      if (!reset_n)   crit_q <= '0;
      else if (accept) crit_q <= bus.miss_addr[BEAT_W-1:0];
   end

   assign fill_start_new  = bus.miss_addr[BEAT_W-1:0];
   assign fill_start_held = crit_q;
`else
   // Byte offset of the miss does not matter when the refill is always in order.
   logic unused_miss_offset;
   assign unused_miss_offset = ^bus.miss_addr[BEAT_W-1:0];
   assign fill_start_new     = '0;
   assign fill_start_held    = '0;
`endif

   // Victim byte offset is ignored: write-back always covers the whole line.
   logic unused_victim_offset;
   assign unused_victim_offset = ^bus.victim_addr[BEAT_W-1:0];

   // Reload on acceptance (WB starts at 0, FILL at its start) and again when
   // write-back hands over to the refill.
   assign cnt_load     = accept || wb_end;
   assign cnt_load_val = accept ? (bus.victim_dirty ? '0 : fill_start_new)
                                : fill_start_held;

   mem_beat_cnt u_beat_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .inc      (beat_done),
      .cnt      (cnt),
      .last     (last)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         miss_base_q   <= '0;
         victim_base_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            miss_base_q   <= bus.miss_addr[ADDR_W-1:BEAT_W];
            victim_base_q <= bus.victim_addr[ADDR_W-1:BEAT_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.miss_req) state_d = bus.victim_dirty ? WB : FILL;
         WB:   if (beat_done && last) state_d = FILL;
         FILL: if (beat_done && last) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.beat_idx     = cnt;
      bus.wr_mem       = (state_q == WB);
      bus.rd_mem       = (state_q == FILL);
      bus.addr_mem     = (state_q == WB) ? {victim_base_q, cnt} : {miss_base_q, cnt};
      bus.data_mem_out = bus.victim_data;
      bus.fill_we      = (state_q == FILL) && bus.ready_mem;
      bus.fill_data    = bus.data_mem_in;
      bus.miss_done    = (state_q == DONE);
      // Stall combinationally in the cycle the miss is raised; a miss seen
      // while reset is held is never accepted, so it does not stall.
      bus.stall_cpu    = (state_q != IDLE) || (bus.miss_req && reset_n);
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
   import cache_pkg::*;

   typedef struct packed {
      logic [8:0]      maddr;
      logic [8:0]      vaddr;
      logic            dirty;
      logic [1:0]      mode;   // 0: ready always, 1: 4 wait cycles at FILL start, 2: toggling
      logic [3:0][7:0] vb;     // victim bytes by beat index
      logic [3:0][7:0] md;     // memory bytes by address[1:0]
      int              exp_done;
      int              exp_nw;
      int              exp_nr;
      logic [3:0][8:0] wa;     // expected write addresses in beat order
      logic [3:0][8:0] ra;     // expected read addresses in beat order
   } vec_t;

   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   vec_t tv [5];

   cache_miss_ctrl_if bus ();

   cache_miss_ctrl dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int  nw, nr, stall, done_c, wait_left;
      logic r;
      nw = 0; nr = 0; stall = 0; done_c = -1; wait_left = 4;
      bus.miss_addr    = v.maddr;
      bus.victim_addr  = v.vaddr;
      bus.victim_dirty = v.dirty;
      bus.miss_req     = 1'b1;
      for (int c = 0; c < 60 && done_c < 0; c++) begin
         // Inputs after acceptance must be ignored.
         if (c == 1) begin
            bus.miss_addr    = ~v.maddr;
            bus.victim_addr  = ~v.vaddr;
            bus.victim_dirty = ~v.dirty;
         end
         r = 1'b1;
         if (v.mode == 2'd1 && bus.rd_mem && wait_left > 0) begin
            r = 1'b0;
            wait_left--;
         end else if (v.mode == 2'd2) begin
            r = (c % 2 == 1);
         end
         bus.ready_mem   = r;
         bus.victim_data = v.vb[bus.beat_idx];
         bus.data_mem_in = v.md[bus.addr_mem[1:0]];
         #1;
         if (c == 0) chk($sformatf("v%0d_stall_c0", id), bus.stall_cpu, 1);
         if (bus.stall_cpu) stall++;
         chk($sformatf("v%0d_rdwr_c%0d", id, c), bus.rd_mem && bus.wr_mem, 0);
         chk($sformatf("v%0d_fillwe_c%0d", id, c), bus.fill_we, bus.rd_mem && bus.ready_mem);
         if (v.mode == 2'd1 && bus.rd_mem && !bus.ready_mem)
            chk($sformatf("v%0d_wait_addr_c%0d", id, c), bus.addr_mem, v.ra[0]);
         if (bus.wr_mem && bus.ready_mem) begin
            if (nw < 4) begin
               chk($sformatf("v%0d_wa%0d", id, nw), bus.addr_mem, v.wa[nw]);
               chk($sformatf("v%0d_wd%0d", id, nw), bus.data_mem_out, v.vb[nw]);
            end
            nw++;
         end
         if (bus.rd_mem && bus.ready_mem) begin
            if (nr < 4) begin
               chk($sformatf("v%0d_ra%0d", id, nr), bus.addr_mem, v.ra[nr]);
               chk($sformatf("v%0d_fd%0d", id, nr), bus.fill_data, v.md[v.ra[nr][1:0]]);
            end
            nr++;
         end
         if (bus.miss_done) done_c = c;
         tick();
      end
      bus.miss_req  = 1'b0;
      bus.ready_mem = 1'b0;
      if (done_c < 0) begin
         bad++;
         total++;
         $display("FAIL v%0d_timeout act=no_miss_done exp=miss_done", id);
      end
      chk($sformatf("v%0d_done_cycle", id), done_c, v.exp_done);
      chk($sformatf("v%0d_stall_cycles", id), stall, v.exp_done + 1);
      chk($sformatf("v%0d_nwr", id), nw, v.exp_nw);
      chk($sformatf("v%0d_nrd", id), nr, v.exp_nr);
      tick();
   endtask

   initial begin
      int beats;
      logic seen;

      // Clean miss, in-order data 11,22,33,44 at 0x004..0x007.
      tv[0] = '0;
      tv[0].maddr = 9'h007; tv[0].vaddr = 9'h1F0; tv[0].dirty = 1'b0; tv[0].mode = 2'd0;
      tv[0].md = {8'h44, 8'h33, 8'h22, 8'h11};
      tv[0].exp_done = 5; tv[0].exp_nw = 0; tv[0].exp_nr = 4;
      // Dirty miss: write back 0x18C..0x18F, then refill around 0x09B.
      tv[1] = '0;
      tv[1].maddr = 9'h09B; tv[1].vaddr = 9'h18C; tv[1].dirty = 1'b1; tv[1].mode = 2'd0;
      tv[1].vb = {8'hBB, 8'hAA, 8'h99, 8'h88};
      tv[1].md = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
      tv[1].exp_done = 9; tv[1].exp_nw = 4; tv[1].exp_nr = 4;
      tv[1].wa = {9'h18F, 9'h18E, 9'h18D, 9'h18C};
      // Clean miss with 4 memory wait cycles at the start of FILL.
      tv[2] = '0;
      tv[2].maddr = 9'h007; tv[2].vaddr = 9'h000; tv[2].dirty = 1'b0; tv[2].mode = 2'd1;
      tv[2].md = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      tv[2].exp_done = 9; tv[2].exp_nw = 0; tv[2].exp_nr = 4;
      // Dirty miss with ready_mem toggling every cycle.
      tv[3] = tv[1];
      tv[3].mode = 2'd2;
      tv[3].exp_done = 16;
      // Clean miss at offset 2.
      tv[4] = '0;
      tv[4].maddr = 9'h102; tv[4].vaddr = 9'h0F0; tv[4].dirty = 1'b0; tv[4].mode = 2'd0;
      tv[4].md = {8'h78, 8'h56, 8'h34, 8'h12};
      tv[4].exp_done = 5; tv[4].exp_nw = 0; tv[4].exp_nr = 4;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      tv[0].ra = {9'h006, 9'h005, 9'h004, 9'h007};
      tv[1].ra = {9'h09A, 9'h099, 9'h098, 9'h09B};
      tv[4].ra = {9'h101, 9'h100, 9'h103, 9'h102};
`else
      tv[0].ra = {9'h007, 9'h006, 9'h005, 9'h004};
      tv[1].ra = {9'h09B, 9'h09A, 9'h099, 9'h098};
      tv[4].ra = {9'h103, 9'h102, 9'h101, 9'h100};
`endif
      tv[2].ra = tv[0].ra;
      tv[3].ra = tv[1].ra;

      // Reset with a miss pending: nothing may be requested or stalled.
      reset_n = 1'b0;
      bus.miss_req = 1'b1; bus.miss_addr = 9'h1FF; bus.victim_dirty = 1'b1;
      bus.victim_addr = 9'h1FF; bus.victim_data = 8'h00; bus.data_mem_in = 8'h00;
      bus.ready_mem = 1'b1;
      tick();
      tick();
      chk("rst_rd_mem", bus.rd_mem, 0);
      chk("rst_wr_mem", bus.wr_mem, 0);
      chk("rst_fill_we", bus.fill_we, 0);
      chk("rst_miss_done", bus.miss_done, 0);
      chk("rst_stall_cpu", bus.stall_cpu, 0);
      chk("rst_beat_idx", bus.beat_idx, 0);
      chk("rst_addr_mem", bus.addr_mem, 0);
      bus.miss_req = 1'b0;
      bus.ready_mem = 1'b0;
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_vec(i, tv[i]);

      // Reset in the middle of a refill.
      bus.miss_addr = 9'h007; bus.victim_dirty = 1'b0; bus.miss_req = 1'b1;
      bus.ready_mem = 1'b1; bus.data_mem_in = 8'h5A;
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         #1;
         if (bus.rd_mem && bus.ready_mem) beats++;
         tick();
      end
      chk("mid_reset_reached_beat2", beats, 2);
      reset_n = 1'b0;
      tick();
      chk("mid_reset_rd_mem", bus.rd_mem, 0);
      chk("mid_reset_stall", bus.stall_cpu, 0);
      chk("mid_reset_fill_we", bus.fill_we, 0);
      chk("mid_reset_done", bus.miss_done, 0);
      chk("mid_reset_beat_idx", bus.beat_idx, 0);
      reset_n = 1'b1;
      bus.miss_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bus.miss_done || bus.rd_mem || bus.wr_mem) seen = 1'b1;
         tick();
      end
      chk("post_reset_quiet", seen, 0);
      run_vec(5, tv[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
